// File: rtl/data_mem_mmio_if.sv
// ---------------------------------------------------------------------------
// data_mem_mmio_if
// Purpose : bundles the CPU load/store port and the byte output stream of
//           data_mem_mmio into one interface.
// Signals : MemWrite    - CPU store strobe (CPU -> memory)
//           Mem_WrAddr  - CPU byte address for loads and stores
//           Mem_WrData  - CPU store data
//           ReadData    - load data returned to the CPU (combinational)
//           out_valid   - output FIFO holds a byte
//           out_data    - byte at the FIFO head (0 when empty)
//           out_ready   - downstream consumer takes out_data this cycle
// Modports: master - CPU / consumer side, slave - the memory block
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface data_mem_mmio_if;
   logic        MemWrite;
   logic [31:0] Mem_WrAddr;
   logic [31:0] Mem_WrData;
   logic [31:0] ReadData;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_ready;

   modport master (
      output MemWrite, Mem_WrAddr, Mem_WrData, out_ready,
      input  ReadData, out_valid, out_data
   );

   modport slave (
      input  MemWrite, Mem_WrAddr, Mem_WrData, out_ready,
      output ReadData, out_valid, out_data
   );
endinterface

// File: rtl/data_mem_mmio.sv
// ---------------------------------------------------------------------------
// data_mem_mmio
// Purpose : data memory for a single-cycle CPU with a small MMIO block:
//           word RAM, a byte output FIFO (TXDATA/STATUS), a free-running
//           cycle counter (CYCLE) and a saturating drop counter (DROPS).
// Ports   : clk   - single clock, all state changes on its rising edge
//           reset - synchronous, active-high
//           bus   - data_mem_mmio_if.slave (CPU load/store + byte stream)
// Map     : 0x0000_0000 .. 4*RAM_WORDS-4  RAM
//           0x0000_1000  store: push byte / load: STATUS
//           0x0000_1004  CYCLE (read/write)
//           0x0000_1008  DROPS (read only)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module data_mem_mmio #(
   parameter int RAM_WORDS  = 64,
   parameter int FIFO_DEPTH = 4
) (
   input logic           clk,
   input logic           reset,
   data_mem_mmio_if.slave bus
);

   localparam int AW = (RAM_WORDS  > 1) ? $clog2(RAM_WORDS)  : 1;
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   // ---------------- address decode (byte offset ignored) ----------------
   logic [29:0]   word_addr;
   logic          sel_ram, sel_tx, sel_cyc, sel_drops;
   logic [AW-1:0] ram_idx;

   assign word_addr = bus.Mem_WrAddr[31:2];
   assign sel_ram   = (bus.Mem_WrAddr[31:AW+2] == '0);
   assign sel_tx    = (word_addr == 30'h0000_0400);
   assign sel_cyc   = (word_addr == 30'h0000_0401);
   assign sel_drops = (word_addr == 30'h0000_0402);
   assign ram_idx   = bus.Mem_WrAddr[AW+1:2];

   // ---------------- state ----------------
   // RAM is read combinationally so a single-cycle CPU finishes a load in
   // the same cycle; it is never cleared by reset.
   logic [31:0]   ram_q [RAM_WORDS];
   logic [7:0]    fifo_mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q,  count_d;
   logic [31:0]   cycle_q,  cycle_d;
   logic [7:0]    drops_q,  drops_d;

   // ---------------- FIFO control ----------------
   logic fifo_full, fifo_empty;
   logic pop, push_req, push_ok, push_drop;

   assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
   assign fifo_empty = (count_q == '0);
   assign pop        = !fifo_empty && bus.out_ready;
   assign push_req   = bus.MemWrite && sel_tx;
   // A pop frees the slot this cycle, so a push into a full FIFO still fits.
   assign push_ok    = push_req && (!fifo_full || pop);
   assign push_drop  = push_req && fifo_full && !pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      cycle_d  = cycle_q + 32'd1;
      drops_d  = drops_q;

      if (push_ok) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push_ok, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      // A CPU write to CYCLE takes priority over the free-running increment.
      if (bus.MemWrite && sel_cyc) begin
         cycle_d = bus.Mem_WrData;
      end
      if (push_drop && (drops_q != 8'hFF)) begin
         drops_d = drops_q + 8'd1;
      end
   end

   // ---------------- registers ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         cycle_q  <= '0;
         drops_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         cycle_q  <= cycle_d;
         drops_q  <= drops_d;
      end
   end

   // Storage arrays carry no reset; writes are still blocked while reset=1.
   always_ff @(posedge clk) begin
      if (!reset && bus.MemWrite && sel_ram) begin
         ram_q[ram_idx] <= bus.Mem_WrData;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && push_ok) begin
         fifo_mem_q[wr_ptr_q] <= bus.Mem_WrData[7:0];
      end
   end

   // ---------------- outputs ----------------
   logic [31:0] status;

   always_comb begin
      status          = '0;
      status[0]       = fifo_full;
      status[1]       = fifo_empty;
      status[2 +: CW] = count_q;
   end

   assign bus.out_valid = !fifo_empty;
   assign bus.out_data  = fifo_empty ? 8'h00 : fifo_mem_q[rd_ptr_q];

   always_comb begin
      bus.ReadData = '0;
      if (sel_ram) begin
         bus.ReadData = ram_q[ram_idx];
      end else if (sel_tx) begin
         bus.ReadData = status;
      end else if (sel_cyc) begin
         bus.ReadData = cycle_q;
      end else if (sel_drops) begin
         bus.ReadData = {24'h0, drops_q};
      end
   end

endmodule

// File: tb/tb_data_mem_mmio.sv
// ---------------------------------------------------------------------------
// tb_data_mem_mmio
// Purpose : directed self-checking bench for data_mem_mmio (RAM_WORDS=64,
//           FIFO_DEPTH=4). Inputs change and outputs are sampled on the
//           falling edge; the DUT updates on the rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_data_mem_mmio;

   logic clk = 1'b0;
   logic reset;

   data_mem_mmio_if bus();

   data_mem_mmio #(
      .RAM_WORDS  (64),
      .FIFO_DEPTH (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #10 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [7:0] drain_exp [4];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Present a load address and check the combinational ReadData.
   task automatic load_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      bus.Mem_WrAddr = addr;
      #1;
      check(tag, bus.ReadData, exp);
   endtask

   // One-cycle store, called just after a falling edge.
   task automatic store(input logic [31:0] addr, input logic [31:0] data);
      bus.MemWrite   = 1'b1;
      bus.Mem_WrAddr = addr;
      bus.Mem_WrData = data;
      @(negedge clk);
      bus.MemWrite   = 1'b0;
      $display("[TB] store addr=0x%08h data=0x%08h", addr, data);
   endtask

   initial begin
      reset          = 1'b1;
      bus.MemWrite   = 1'b0;
      bus.Mem_WrAddr = '0;
      bus.Mem_WrData = '0;
      bus.out_ready  = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;

      // Reset state
      check("rst_valid", {31'h0, bus.out_valid}, 32'h0);
      check("rst_data", {24'h0, bus.out_data}, 32'h0);
      load_chk("rst_status", 32'h1000, 32'h0000_0002);
      load_chk("rst_cycle", 32'h1004, 32'h0);
      load_chk("rst_drops", 32'h1008, 32'h0);
      @(negedge clk);

      // RAM store / load, byte offset ignored, top word, first word past RAM
      store(32'h0000_0010, 32'hDEAD_BEEF);
      load_chk("ram_raw", 32'h0000_0013, 32'hDEAD_BEEF);
      store(32'h0000_00FC, 32'h1234_5678);
      load_chk("ram_top", 32'h0000_00FC, 32'h1234_5678);
      load_chk("ram_beyond", 32'h0000_0100, 32'h0);
      $display("[TB] ram read-after-write checked");

      // Fill FIFO with out_ready=0; fifth push is dropped
      bus.out_ready  = 1'b0;
      bus.MemWrite   = 1'b1;
      bus.Mem_WrAddr = 32'h1000;
      bus.Mem_WrData = 32'h41;
      #1;
      check("no_bypass_valid", {31'h0, bus.out_valid}, 32'h0);
      @(negedge clk);
      bus.MemWrite = 1'b0;
      #1;
      check("push1_valid", {31'h0, bus.out_valid}, 32'h1);
      check("push1_data", {24'h0, bus.out_data}, 32'h41);
      for (int i = 0; i < 4; i++) begin
         store(32'h1000, 32'(8'h42 + i));
      end
      load_chk("full_status", 32'h1000, 32'h0000_0011);
      load_chk("full_drops", 32'h1008, 32'h1);
      check("held_data", {24'h0, bus.out_data}, 32'h41);

      // Drain
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("drain_%0d", i), {24'h0, bus.out_data}, 32'(8'h41 + i));
         @(negedge clk);
         $display("[TB] pop %0d", i);
      end
      bus.out_ready = 1'b0;
      #1;
      check("drained_valid", {31'h0, bus.out_valid}, 32'h0);
      check("drained_data", {24'h0, bus.out_data}, 32'h0);
      load_chk("drained_status", 32'h1000, 32'h0000_0002);
      @(negedge clk);

      // Full FIFO: push and pop in the same cycle
      for (int i = 0; i < 4; i++) begin
         store(32'h1000, 32'(8'h61 + i));
      end
      load_chk("pp_pre_status", 32'h1000, 32'h0000_0011);
      bus.out_ready  = 1'b1;
      bus.MemWrite   = 1'b1;
      bus.Mem_WrAddr = 32'h1000;
      bus.Mem_WrData = 32'h55;
      #1;
      check("pp_head", {24'h0, bus.out_data}, 32'h61);
      @(negedge clk);
      bus.MemWrite  = 1'b0;
      bus.out_ready = 1'b0;
      $display("[TB] push 0x55 with pop on full FIFO");
      load_chk("pp_status", 32'h1000, 32'h0000_0011);
      load_chk("pp_drops", 32'h1008, 32'h1);
      drain_exp[0] = 8'h62;
      drain_exp[1] = 8'h63;
      drain_exp[2] = 8'h64;
      drain_exp[3] = 8'h55;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("pp_drain_%0d", i), {24'h0, bus.out_data}, {24'h0, drain_exp[i]});
         @(negedge clk);
         $display("[TB] pop %0d", i);
      end
      bus.out_ready = 1'b0;
      #1;
      check("pp_empty", {31'h0, bus.out_valid}, 32'h0);
      @(negedge clk);

      // CYCLE load and wrap
      store(32'h1004, 32'hFFFF_FFFE);
      load_chk("cyc_0", 32'h1004, 32'hFFFF_FFFE);
      @(negedge clk);
      load_chk("cyc_1", 32'h1004, 32'hFFFF_FFFF);
      @(negedge clk);
      load_chk("cyc_wrap", 32'h1004, 32'h0000_0000);
      @(negedge clk);

      // Unmapped address
      store(32'h0000_0000, 32'h0BAD_C0DE);
      load_chk("unm_load", 32'h0000_2000, 32'h0);
      store(32'h1004, 32'd100);
      store(32'h0000_2000, 32'hCAFE_F00D);
      load_chk("unm_cycle", 32'h1004, 32'd101);
      load_chk("unm_ram0", 32'h0000_0000, 32'h0BAD_C0DE);
      load_chk("unm_ram10", 32'h0000_0010, 32'hDEAD_BEEF);
      load_chk("unm_status", 32'h1000, 32'h0000_0002);
      load_chk("unm_drops", 32'h1008, 32'h1);
      @(negedge clk);

      // DROPS saturation and read-only
      for (int i = 0; i < 4; i++) begin
         store(32'h1000, 32'(8'h71 + i));
      end
      bus.MemWrite   = 1'b1;
      bus.Mem_WrAddr = 32'h1000;
      bus.Mem_WrData = 32'h99;
      repeat (256) @(negedge clk);
      bus.MemWrite = 1'b0;
      $display("[TB] 256 pushes into full FIFO");
      load_chk("drops_sat", 32'h1008, 32'h0000_00FF);
      store(32'h1008, 32'h0);
      load_chk("drops_ro", 32'h1008, 32'h0000_00FF);
      check("sat_head", {24'h0, bus.out_data}, 32'h71);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      load_chk("three_status", 32'h1000, 32'h0000_000C);
      check("three_head", {24'h0, bus.out_data}, 32'h72);
      @(negedge clk);

      // Reset mid-drain with store and pop attempted during reset
      reset          = 1'b1;
      bus.MemWrite   = 1'b1;
      bus.Mem_WrAddr = 32'h0000_0010;
      bus.Mem_WrData = 32'hFFFF_FFFF;
      bus.out_ready  = 1'b1;
      @(negedge clk);
      reset         = 1'b0;
      bus.MemWrite  = 1'b0;
      bus.out_ready = 1'b0;
      $display("[TB] reset pulse with 3 bytes queued");
      #1;
      check("rr_valid", {31'h0, bus.out_valid}, 32'h0);
      check("rr_data", {24'h0, bus.out_data}, 32'h0);
      load_chk("rr_cycle", 32'h1004, 32'h0);
      load_chk("rr_status", 32'h1000, 32'h0000_0002);
      load_chk("rr_drops", 32'h1008, 32'h0);
      load_chk("rr_ram", 32'h0000_0010, 32'hDEAD_BEEF);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/data_mem_mmio.md
DATA_MEM_MMIO -- requirements
Module: data_mem_mmio

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 64, meaning number of 32-bit data RAM words (power of 2, max 1024).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning number of byte entries in the output FIFO (power of 2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port MemWrite  input  1  CPU store strobe for the current cycle.
REQ-006 SHALL have port Mem_WrAddr  input  32  CPU byte address, used for both loads and stores.
REQ-007 SHALL have port Mem_WrData  input  32  CPU store data.
REQ-008 SHALL have port ReadData  output  32  load data returned to the CPU.
REQ-009 SHALL have port out_valid  output  1  output FIFO has a byte available.
REQ-010 SHALL have port out_data  output  8  byte at the FIFO head.
REQ-011 SHALL have port out_ready  input  1  downstream consumer accepts out_data this cycle.

Function
REQ-012 SHALL decode the address map on Mem_WrAddr[31:2], ignoring Mem_WrAddr[1:0]: RAM at 0x0000_0000 .. 4*RAM_WORDS-4; TXDATA/STATUS at 0x0000_1000; CYCLE at 0x0000_1004; DROPS at 0x0000_1008; all other addresses unmapped.
REQ-013 SHALL drive ReadData combinationally from the current address with zero added latency, so a single-cycle CPU can complete a load in the same cycle.
REQ-014 SHALL perform every store on the rising clk edge where MemWrite=1; when MemWrite=0, no state changes except CYCLE increment and FIFO pop.
REQ-015 SHALL write the full 32-bit Mem_WrData to RAM[addr[log2(RAM_WORDS)+1:2]] on a RAM store, with read-after-write visible in the next cycle.
REQ-016 SHALL return 0 for loads from unmapped addresses and ignore stores to them.
REQ-017 SHALL, on a store to 0x1000, push Mem_WrData[7:0] into the FIFO if not full; a push when full without a same-cycle pop SHALL be dropped and increment DROPS.
REQ-018 SHALL return STATUS on a load from 0x1000: bit0=full, bit1=empty, bits[7:2]=entry count, all other bits 0.
REQ-019 SHALL pop the head entry on each cycle where out_valid=1 and out_ready=1.
REQ-020 SHALL accept a push and a pop in the same cycle when the FIFO is full, leaving count unchanged and incrementing no counter.
REQ-021 SHALL let a push into an empty FIFO assert out_valid on the next cycle; no same-cycle bypass.
REQ-022 SHALL hold out_data stable while out_valid=1 and out_ready=0, and drive out_data=0 when the FIFO is empty.
REQ-023 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH, tracking count separately (0..FIFO_DEPTH).
REQ-024 SHALL increment the 32-bit CYCLE register every cycle with wrap 0xFFFF_FFFF->0; a store to 0x1004 SHALL load Mem_WrData, overriding that cycle's increment.
REQ-025 SHALL keep DROPS as an 8-bit counter saturating at 255, read zero-extended; stores to 0x1008 SHALL be ignored.

Reset
REQ-026 SHALL, when reset=1 at a rising edge, clear FIFO pointers, count, CYCLE and DROPS to 0, so that out_valid=0 and out_data=0 on the following cycle.
REQ-027 SHALL not clear RAM contents on reset.
REQ-028 SHALL ignore MemWrite, and push, pop and store effects, in any cycle where reset=1; reset mid-drain discards all queued bytes.

Verification
REQ-029 SHALL cover: store 0xDEADBEEF to 0x0000_0010, next-cycle load from 0x0000_0013 -> ReadData=0xDEADBEEF.
REQ-030 SHALL cover: out_ready=0, push bytes 0x41,0x42,0x43,0x44,0x45 to 0x1000 -> STATUS=0x11 (full, count 4), DROPS=1, then out_ready=1 -> out_data sequence 0x41..0x44, then out_valid=0 and STATUS=0x02.
REQ-031 SHALL cover: FIFO full and out_ready=1, push 0x55 in the same cycle -> count stays 4, DROPS unchanged, 0x55 emerges fourth after the pop.
REQ-032 SHALL cover: store 0xFFFF_FFFE to 0x1004 -> load 0x1004 reads 0xFFFF_FFFE, 0xFFFF_FFFF, then 0x0000_0000 on the following cycles.
REQ-033 SHALL cover: load from 0x0000_2000 -> ReadData=0; store there leaves RAM, FIFO and counters unchanged.
REQ-034 SHALL cover: 3 bytes queued, reset pulsed for 1 cycle -> out_valid=0, STATUS=0x02, CYCLE=0, and RAM word written before reset still reads back.
